multi_cycle_mips: RTL and testbench

MULTI_CYCLE_MIPS -- requirements
Module: multi_cycle_mips

---
 rtl/multi_cycle_mips.sv | 221 ++++++++++++++++++++++
 tb/tb_multi_cycle_mips.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_mips.sv
// rtl/multi_cycle_mips.sv - multi-cycle MIPS subset core (IF/ID/EX/MEM/WB FSM)
// Optional: define MIPS_BNE_EN to decode opcode 000101 as bne.
module multi_cycle_mips #(
    parameter int          DMEM_AW  = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        IR_addr,
    input  logic [31:0]        IR,
    input  logic               IR_valid,
    output logic [31:0]        RF_writedata,
    output logic               RF_we,
    input  logic [31:0]        ReadDataMem,
    input  logic               mem_ready,
    output logic               CEN,
    output logic               WEN,
    output logic               OEN,
    output logic [DMEM_AW-1:0] A,
    output logic [31:0]        ReadData2
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    // Shared result register: ALU result, memory address, load data or link address.
    logic [31:0] r_alu;
    logic [4:0]  r_wdest;
    logic        r_rf_we;
    logic        r_cen;
    logic        r_wen;
    logic [31:0] r_rf [0:31];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_alu;
    logic        w_funct_ok;
    logic [31:0] w_mem_addr;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_target;
    logic        w_is_branch;
    logic        w_take;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];

    assign w_mem_addr    = r_a + r_imm;
    assign w_br_target   = r_npc + {r_imm[29:0], 2'b00};
    assign w_jump_target = {r_npc[31:28], r_ir[25:0], 2'b00};

`ifdef MIPS_BNE_EN
    assign w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_take      = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
`else
    assign w_is_branch = (w_op == OP_BEQ);
    assign w_take      = (r_a == r_b);
`endif

    always_comb begin
        w_alu      = 32'h0;
        w_funct_ok = 1'b1;
        case (w_funct)
            F_ADD:   w_alu = r_a + r_b;
            F_SUB:   w_alu = r_a - r_b;
            F_AND:   w_alu = r_a & r_b;
            F_OR:    w_alu = r_a | r_b;
            F_SLT:   w_alu = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
            default: w_funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IF;
            r_pc    <= RESET_PC;
            r_npc   <= 32'h0;
            r_ir    <= 32'h0;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_imm   <= 32'h0;
            r_alu   <= 32'h0;
            r_wdest <= 5'd0;
            r_rf_we <= 1'b0;
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else begin
            // Commit happens at the end of the cycle in which RF_we is high.
            if (r_rf_we && (r_wdest != 5'd0)) begin
                r_rf[r_wdest] <= r_alu;
            end

            case (r_state)
                S_IF: begin
                    if (IR_valid) begin
                        r_ir    <= IR;
                        r_npc   <= r_pc + 32'd4;
                        r_state <= S_ID;
                    end
                end

                S_ID: begin
                    r_a     <= r_rf[w_rs];
                    r_b     <= r_rf[w_rt];
                    r_imm   <= {{16{r_ir[15]}}, r_ir[15:0]};
                    r_state <= S_EX;
                    if (w_op == OP_JAL) begin
                        r_alu   <= r_npc;
                        r_wdest <= 5'd31;
                        r_rf_we <= 1'b1;
                    end
                end

                S_EX: begin
                    r_rf_we <= 1'b0;
                    case (w_op)
                        OP_RTYPE: begin
                            if (w_funct == F_JR) begin
                                r_pc    <= r_a;
                                r_state <= S_IF;
                            end else if (w_funct_ok) begin
                                r_alu   <= w_alu;
                                r_wdest <= w_rd;
                                r_rf_we <= 1'b1;
                                r_state <= S_WB;
                            end else begin
                                r_pc    <= r_npc;
                                r_state <= S_IF;
                            end
                        end
                        OP_LW, OP_SW: begin
                            r_alu   <= w_mem_addr;
                            r_cen   <= 1'b0;
                            r_wen   <= (w_op == OP_LW);
                            r_state <= S_MEM;
                        end
                        OP_J, OP_JAL: begin
                            r_pc    <= w_jump_target;
                            r_state <= S_IF;
                        end
                        default: begin
                            r_pc    <= (w_is_branch && w_take) ? w_br_target : r_npc;
                            r_state <= S_IF;
                        end
                    endcase
                end

                S_MEM: begin
                    if (mem_ready) begin
                        r_cen <= 1'b1;
                        r_wen <= 1'b1;
                        if (w_op == OP_LW) begin
                            r_alu   <= ReadDataMem;
                            r_wdest <= w_rt;
                            r_rf_we <= 1'b1;
                            r_state <= S_WB;
                        end else begin
                            r_pc    <= r_npc;
                            r_state <= S_IF;
                        end
                    end
                end

                S_WB: begin
                    r_rf_we <= 1'b0;
                    r_pc    <= r_npc;
                    r_state <= S_IF;
                end

                default: r_state <= S_IF;
            endcase
        end
    end

    assign IR_addr      = r_pc;
    assign RF_writedata = r_alu;
    assign RF_we        = r_rf_we;
    assign CEN          = r_cen;
    assign WEN          = r_wen;
    assign OEN          = 1'b0;
    assign A            = r_alu[DMEM_AW+1:2];
    assign ReadData2    = r_b;

endmodule

// File: tb/tb_multi_cycle_mips.sv
// tb/tb_multi_cycle_mips.sv - directed scoreboard bench for multi_cycle_mips
module tb_multi_cycle_mips;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IR_addr;
    logic [31:0] IR;
    logic        IR_valid;
    logic [31:0] RF_writedata;
    logic        RF_we;
    logic [31:0] ReadDataMem;
    logic        mem_ready;
    logic        CEN;
    logic        WEN;
    logic        OEN;
    logic [6:0]  A;
    logic [31:0] ReadData2;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:127];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int last_fetch_cyc;
    logic [31:0] last_pc;

    logic [31:0] exp_q[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          rd_idx = 0;

    multi_cycle_mips #(.DMEM_AW(7), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr), .IR(IR), .IR_valid(IR_valid),
        .RF_writedata(RF_writedata), .RF_we(RF_we), .ReadDataMem(ReadDataMem),
        .mem_ready(mem_ready), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
        .ReadData2(ReadData2)
    );

    always #5 clk = ~clk;

    assign IR          = imem[IR_addr[7:2]];
    assign ReadDataMem = dmem[A];

    // Cycle 1 is the first cycle whose closing edge sees rst_n high.
    always @(posedge clk) cyc <= (!rst_n) ? 1 : cyc + 1;

    always @(negedge clk) begin
        if (RF_we === 1'b1) begin
            obs_data.push_back(RF_writedata);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick();
        tick();
        chk({tag, "_rst_ir_addr"}, IR_addr, 32'h0);
        chk({tag, "_rst_cen"}, {31'd0, CEN}, 32'd1);
        chk({tag, "_rst_wen"}, {31'd0, WEN}, 32'd1);
        chk({tag, "_rst_oen"}, {31'd0, OEN}, 32'd0);
        chk({tag, "_rst_rf_we"}, {31'd0, RF_we}, 32'd0);
        rst_n          = 1'b1;
        last_pc        = 32'h0;
        last_fetch_cyc = cyc;
    endtask

    task automatic expect_fetch(input logic [31:0] addr, input int lat, input string tag);
        int k;
        k = 0;
        while (IR_addr === last_pc && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_addr"}, IR_addr, addr);
        chk({tag, "_lat"}, cyc - last_fetch_cyc, lat);
        last_pc        = IR_addr;
        last_fetch_cyc = cyc;
    endtask

    task automatic drain(input string tag);
        logic [31:0] want;
        logic [31:0] got;
        chk({tag, "_wr_count"}, obs_data.size() - rd_idx, exp_q.size());
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = 32'bx;
            if (rd_idx < obs_data.size()) begin
                got = obs_data[rd_idx];
                rd_idx++;
            end
            chk({tag, "_wr_data"}, got, want);
        end
        rd_idx = obs_data.size();
    endtask

    initial begin
        int n0;
        rst_n     = 1'b0;
        IR_valid  = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000;
        for (int i = 0; i < 128; i++) dmem[i] = 32'h0;
        dmem[0] = 32'd5;
        dmem[1] = 32'd3;
        dmem[2] = 32'd7;

        // Loads, ALU ops and an unknown funct, all zero-wait.
        imem[0]  = enc_i(6'b100011, 5'd0, 5'd1, 16'd0);
        imem[1]  = enc_i(6'b100011, 5'd0, 5'd1, 16'd8);
        imem[2]  = enc_i(6'b100011, 5'd0, 5'd2, 16'd4);
        imem[3]  = enc_r(5'd1, 5'd2, 5'd3, 6'b100010);
        imem[4]  = enc_r(5'd2, 5'd1, 5'd4, 6'b101010);
        imem[5]  = enc_r(5'd1, 5'd2, 5'd5, 6'b100000);
        imem[6]  = enc_r(5'd1, 5'd2, 5'd6, 6'b100100);
        imem[7]  = enc_r(5'd1, 5'd2, 5'd7, 6'b100101);
        imem[8]  = enc_r(5'd1, 5'd2, 5'd8, 6'b101010);
        imem[9]  = enc_r(5'd1, 5'd2, 5'd9, 6'b000111);
        do_reset("a");
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        expect_fetch(32'h04, 5, "lw0");
        chk("lw0_we_cycle", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, 32'd5);
        expect_fetch(32'h08, 5, "lw1");
        expect_fetch(32'h0C, 5, "lw2");
        expect_fetch(32'h10, 4, "sub");
        expect_fetch(32'h14, 4, "slt_t");
        expect_fetch(32'h18, 4, "add");
        expect_fetch(32'h1C, 4, "and");
        expect_fetch(32'h20, 4, "or");
        expect_fetch(32'h24, 4, "slt_f");
        expect_fetch(32'h28, 3, "bad_funct");
        expect_fetch(32'h2C, 3, "bad_op");
        drain("a");

        // Control flow, fetch stall, store stall, $0 handling, opcode 000101.
        for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000;
        imem[0]  = enc_i(6'b100011, 5'd0, 5'd1, 16'd8);
        imem[1]  = enc_i(6'b100011, 5'd0, 5'd2, 16'd4);
        imem[2]  = enc_i(6'b000100, 5'd1, 5'd2, 16'd5);
        imem[3]  = enc_j(6'b000010, 26'd4);
        imem[4]  = enc_i(6'b000100, 5'd1, 5'd1, 16'hFFFF);
        imem[5]  = enc_j(6'b000010, 26'd8);
        imem[8]  = enc_j(6'b000011, 26'd16);
        imem[9]  = enc_i(6'b101011, 5'd0, 5'd31, 16'd12);
        imem[10] = enc_i(6'b000101, 5'd1, 5'd2, 16'd1);
        imem[12] = enc_r(5'd1, 5'd2, 5'd0, 6'b100000);
        imem[13] = enc_i(6'b101011, 5'd0, 5'd0, 16'd16);
        imem[16] = enc_r(5'd31, 5'd0, 5'd0, 6'b001000);
        IR_valid = 1'b0;
        do_reset("b");
        tick();
        tick();
        chk("if_hold_addr", IR_addr, 32'h0);
        IR_valid       = 1'b1;
        last_fetch_cyc = cyc;
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'h24);
        exp_q.push_back(32'd10);
        expect_fetch(32'h04, 5, "b_lw1");
        expect_fetch(32'h08, 5, "b_lw2");
        expect_fetch(32'h0C, 3, "beq_not_taken");
        expect_fetch(32'h10, 3, "j");
        tick();
        tick();
        tick();
        chk("beq_self_taken", IR_addr, 32'h10);
        last_fetch_cyc = cyc;
        imem[4] = enc_i(6'b000100, 5'd1, 5'd2, 16'hFFFF);
        expect_fetch(32'h14, 3, "beq_ne");
        expect_fetch(32'h20, 3, "j2");
        expect_fetch(32'h40, 3, "jal");
        expect_fetch(32'h24, 3, "jr");
        mem_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sw_stall_cen", {31'd0, CEN}, 32'd0);
            chk("sw_stall_wen", {31'd0, WEN}, 32'd0);
            chk("sw_stall_a", {25'd0, A}, 32'd3);
            chk("sw_stall_rd2", ReadData2, 32'h24);
            if (k == 3) mem_ready = 1'b1;
        end
        expect_fetch(32'h28, 7, "sw_stall");
`ifdef MIPS_BNE_EN
        expect_fetch(32'h30, 3, "bne_taken");
`else
        expect_fetch(32'h2C, 3, "bne_as_nop");
        expect_fetch(32'h30, 3, "nop_2c");
`endif
        expect_fetch(32'h34, 4, "add_r0");
        tick();
        tick();
        tick();
        chk("r0_reads_zero", ReadData2, 32'h0);
        chk("sw_r0_a", {25'd0, A}, 32'd4);
        chk("sw_r0_cen", {31'd0, CEN}, 32'd0);
        expect_fetch(32'h38, 4, "sw_r0");
        drain("b");

        // Reset while a load is stalled in MEM.
        imem[0]   = enc_i(6'b100011, 5'd0, 5'd1, 16'd8);
        mem_ready = 1'b0;
        do_reset("c");
        n0 = obs_data.size();
        tick();
        tick();
        tick();
        chk("lw_mem_cen", {31'd0, CEN}, 32'd0);
        chk("lw_mem_wen", {31'd0, WEN}, 32'd1);
        tick();
        tick();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("abort_ir_addr", IR_addr, 32'h0);
        chk("abort_cen", {31'd0, CEN}, 32'd1);
        chk("abort_rf_we", {31'd0, RF_we}, 32'd0);
        imem[0]        = enc_i(6'b101011, 5'd0, 5'd1, 16'd0);
        rst_n          = 1'b1;
        last_pc        = 32'h0;
        last_fetch_cyc = cyc;
        tick();
        tick();
        tick();
        chk("reg_cleared", ReadData2, 32'h0);
        chk("sw_wen", {31'd0, WEN}, 32'd0);
        chk("abort_no_write", obs_data.size() - n0, 32'd0);
        expect_fetch(32'h04, 4, "sw_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
